// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-lite slave backed by a word-addressed memory with a fixed
// number of wait states in every OKAY data phase and a two-cycle ERROR response
// for unmapped addresses.
//
// Ports:
//   hclk    - clock, all state changes on the rising edge
//   hreset  - synchronous active-high reset (memory contents are retained)
//   hsel    - slave select, sampled with the address phase
//   htrans  - transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   haddr   - word address
//   hwrite  - 1 = write, 0 = read
//   hwdata  - write data, sampled in the final cycle of the data phase
//   hrdata  - registered read data, held for the whole read data phase
//   hready  - data-phase completion / address-phase acceptance
//   hresp   - 0 = OKAY, 1 = ERROR
module ahb_slave_mem #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 128,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel,
    input  logic [1:0]            htrans,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic                  hwrite,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  hready,
    output logic                  hresp
);

    localparam int unsigned IdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DepthW = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    // Unused when WAIT_STATES is 0, so the wrap-around in that case is harmless.
    localparam logic [3:0] WaitLoad = 4'(WAIT_STATES - 1);
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;

    typedef enum logic [2:0] {StIdle, StWait, StDone, StErr1, StErr2} state_e;

    state_e                  state;
    logic [3:0]              cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic                    err_q;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic                    accept;
    logic                    acc_err;
    logic                    mem_we;
    logic                    fwd;
    logic [DATA_WIDTH-1:0]   rd_data;

    assign accept  = hready && hsel && ((htrans == TransNonseq) || (htrans == TransSeq));
    assign acc_err = ({1'b0, haddr} >= DepthW);

    // A write data phase completes on the edge leaving DONE; reset wins over it.
    assign mem_we  = !hreset && (state == StDone) && write_q && !err_q;

    // A read accepted on the completing edge of a write to the same word must
    // see the new data, not the stale memory word.
    assign fwd     = mem_we && (addr_q == haddr);

    always_comb begin
        rd_data = '0;
        if (!acc_err) begin
            rd_data = fwd ? hwdata : mem[haddr[IdxW-1:0]];
        end
    end

    always_ff @(posedge hclk) begin
        if (mem_we) begin
            mem[addr_q[IdxW-1:0]] <= hwdata;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state   <= StIdle;
            hready  <= 1'b1;
            hresp   <= 1'b0;
            hrdata  <= '0;
            cnt     <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept) begin
            // Only reachable from IDLE, DONE or ERR2, the states that drive hready=1.
            addr_q  <= haddr;
            write_q <= hwrite;
            err_q   <= acc_err;
            if (!hwrite) begin
                hrdata <= rd_data;
            end
            if (acc_err) begin
                state  <= StErr1;
                hready <= 1'b0;
                hresp  <= 1'b1;
            end else if (WAIT_STATES == 0) begin
                state  <= StDone;
                hready <= 1'b1;
                hresp  <= 1'b0;
            end else begin
                state  <= StWait;
                cnt    <= WaitLoad;
                hready <= 1'b0;
                hresp  <= 1'b0;
            end
        end else begin
            unique case (state)
                StWait: begin
                    if (cnt == 4'd0) begin
                        state  <= StDone;
                        hready <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                StErr1: begin
                    state  <= StErr2;
                    hready <= 1'b1;
                    hresp  <= 1'b1;
                end
                default: begin
                    state  <= StIdle;
                    hready <= 1'b1;
                    hresp  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
module tb_ahb_slave_mem;

    localparam logic [1:0] Idle   = 2'b00;
    localparam logic [1:0] Nonseq = 2'b10;
    localparam logic [1:0] Seq    = 2'b11;
    localparam int unsigned MemDepth = 128;

    logic hclk = 1'b0;
    always #5 hclk = ~hclk;

    logic        hreset;
    logic        hsel;
    logic [1:0]  htrans;
    logic [7:0]  haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        cur;  // 0: WAIT_STATES=0 instance, 1: WAIT_STATES=3 instance

    logic        hsel0, hsel3;
    logic [31:0] hrdata0, hrdata3, hrdata;
    logic        hready0, hready3, hready;
    logic        hresp0, hresp3, hresp;

    assign hsel0  = hsel & ~cur;
    assign hsel3  = hsel & cur;
    assign hrdata = cur ? hrdata3 : hrdata0;
    assign hready = cur ? hready3 : hready0;
    assign hresp  = cur ? hresp3  : hresp0;

    ahb_slave_mem #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (MemDepth),
        .WAIT_STATES(0)
    ) u_dut0 (
        .hclk  (hclk),
        .hreset(hreset),
        .hsel  (hsel0),
        .htrans(htrans),
        .haddr (haddr),
        .hwrite(hwrite),
        .hwdata(hwdata),
        .hrdata(hrdata0),
        .hready(hready0),
        .hresp (hresp0)
    );

    ahb_slave_mem #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (MemDepth),
        .WAIT_STATES(3)
    ) u_dut3 (
        .hclk  (hclk),
        .hreset(hreset),
        .hsel  (hsel3),
        .htrans(htrans),
        .haddr (haddr),
        .hwrite(hwrite),
        .hwdata(hwdata),
        .hrdata(hrdata3),
        .hready(hready3),
        .hresp (hresp3)
    );

    typedef struct {
        logic        is_read;
        logic        err;
        logic [31:0] data;
        int          waits;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mdl [2][256];
    logic [31:0] pend_wdata;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one address phase; hwdata carries the previous transfer's write data.
    // Returns at posedge+1 of the cycle after acceptance.
    task automatic xfer(input logic sel, input logic [1:0] tr, input logic [7:0] a,
                        input logic w, input logic [31:0] wd);
        int   n;
        exp_t e;
        logic er;
        hsel   = sel;
        htrans = tr;
        haddr  = a;
        hwrite = w;
        hwdata = pend_wdata;
        n = 0;
        do begin
            @(negedge hclk);
            n++;
        end while (!hready && n < 50);
        if (!hready) check_eq("accept_timeout", 32'(hready), 32'd1);
        @(posedge hclk);
        #1;
        pend_wdata = wd;
        if (sel && tr[1]) begin
            er        = (32'(a) >= MemDepth);
            e.is_read = !w;
            e.err     = er;
            e.waits   = er ? 1 : (cur ? 3 : 0);
            e.data    = (er || w) ? 32'h0 : mdl[cur][a];
            if (w && !er) mdl[cur][a] = wd;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        xfer(1'b0, Idle, 8'h00, 1'b0, 32'h0);
    endtask

    // A cycle with no real transfer must show a zero-wait OKAY.
    task automatic check_idle_cycle(input string tag);
        @(negedge hclk);
        check_eq({tag, "_hready"}, 32'(hready), 32'd1);
        check_eq({tag, "_hresp"}, 32'(hresp), 32'd0);
        @(posedge hclk);
        #1;
    endtask

    // Data-phase monitor: counts stall cycles and compares against the scoreboard.
    logic dp_active = 1'b0;
    int   waits = 0;
    always @(negedge hclk) begin
        exp_t e;
        if (hreset) begin
            dp_active = 1'b0;
            waits     = 0;
        end else begin
            if (dp_active) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_empty", 32'(exp_q.size()), 32'd1);
                    dp_active = 1'b0;
                end else if (!hready) begin
                    waits++;
                    check_eq("stall_resp", 32'(hresp), 32'(exp_q[0].err));
                end else begin
                    e = exp_q.pop_front();
                    check_eq("resp", 32'(hresp), 32'(e.err));
                    check_eq("waits", 32'(waits), 32'(e.waits));
                    if (e.is_read) check_eq("rdata", hrdata, e.data);
                    dp_active = 1'b0;
                    waits     = 0;
                end
            end
            if (hready && hsel && htrans[1]) dp_active = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        hreset = 1'b1;
        hsel   = 1'b0;
        htrans = Idle;
        haddr  = '0;
        hwrite = 1'b0;
        hwdata = '0;
        cur    = 1'b0;
        pend_wdata = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 256; j++) mdl[i][j] = 32'h0;
        end

        repeat (3) @(posedge hclk);
        @(negedge hclk);
        check_eq("rst_hready0", 32'(hready0), 32'd1);
        check_eq("rst_hresp0", 32'(hresp0), 32'd0);
        check_eq("rst_hrdata0", hrdata0, 32'd0);
        check_eq("rst_hready3", 32'(hready3), 32'd1);
        check_eq("rst_hresp3", 32'(hresp3), 32'd0);
        check_eq("rst_hrdata3", hrdata3, 32'd0);
        @(posedge hclk);
        #1 hreset = 1'b0;

        // Zero-wait write then read.
        xfer(1'b1, Nonseq, 8'h10, 1'b1, 32'h0000_00A5);
        xfer(1'b1, Nonseq, 8'h10, 1'b0, 32'h0);
        idle();

        // Back-to-back write/read of the same word exercises forwarding.
        xfer(1'b1, Nonseq, 8'h20, 1'b1, 32'h1234_5678);
        xfer(1'b1, Seq,    8'h20, 1'b0, 32'h0);
        idle();

        // Unmapped read and write, then a normal read (0x90 aliases 0x10 if truncated).
        xfer(1'b1, Nonseq, 8'h90, 1'b0, 32'h0);
        xfer(1'b1, Nonseq, 8'h90, 1'b1, 32'hBAD0_BAD0);
        xfer(1'b1, Nonseq, 8'h10, 1'b0, 32'h0);
        idle();

        // IDLE transfer and deselected write must not touch memory.
        xfer(1'b1, Nonseq, 8'h03, 1'b1, 32'h0000_0033);
        idle();
        xfer(1'b1, Idle, 8'h03, 1'b1, 32'hFFFF_FFFF);
        check_idle_cycle("htrans_idle");
        xfer(1'b0, Nonseq, 8'h03, 1'b1, 32'hFFFF_FFFF);
        check_idle_cycle("hsel_low");
        xfer(1'b1, Nonseq, 8'h03, 1'b0, 32'h0);
        idle();

        // Three wait states per data phase.
        cur = 1'b1;
        xfer(1'b1, Nonseq, 8'h05, 1'b1, 32'hDEAD_BEEF);
        xfer(1'b1, Nonseq, 8'h05, 1'b0, 32'h0);
        idle();

        // Reset in the middle of a stalled write aborts it.
        xfer(1'b1, Nonseq, 8'h07, 1'b1, 32'h7777_7777);
        idle();
        xfer(1'b1, Nonseq, 8'h07, 1'b1, 32'hCAFE_F00D);
        hsel   = 1'b0;
        htrans = Idle;
        hwdata = 32'hCAFE_F00D;
        @(posedge hclk);
        #1 hreset = 1'b1;
        @(posedge hclk);
        #1 hreset = 1'b0;
        exp_q.delete();
        mdl[1][7]  = 32'h7777_7777;
        pend_wdata = 32'h0;
        @(negedge hclk);
        check_eq("post_rst_hready", 32'(hready), 32'd1);
        check_eq("post_rst_hresp", 32'(hresp), 32'd0);
        check_eq("post_rst_hrdata", hrdata, 32'd0);
        @(posedge hclk);
        #1;
        xfer(1'b1, Nonseq, 8'h07, 1'b0, 32'h0);
        idle();

        repeat (3) @(posedge hclk);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
